// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order reorder-buffer retirement (regfile write, store release, branch redirect/flush).
// Optional feature macro COMMIT_WB_BYPASS_EN: the head retires in the same cycle its CDB writeback arrives.
module rob_commit_ctrl #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_W     = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_en_in,
  input  logic [1:0]        alloc_kind_in,
  input  logic [REG_W-1:0]  alloc_rd_in,
  output logic [TAG_W-1:0]  alloc_tag_out,
  output logic              full_out,
  input  logic              wb_en_in,
  input  logic [TAG_W-1:0]  wb_tag_in,
  input  logic [DATA_W-1:0] wb_value_in,
  input  logic              wb_jump_en_in,
  input  logic [ADDR_W-1:0] wb_jump_a_in,
  output logic              commit_reg_en_out,
  output logic [REG_W-1:0]  commit_rd_out,
  output logic [DATA_W-1:0] commit_value_out,
  output logic [TAG_W-1:0]  commit_tag_out,
  output logic              commit_store_en_out,
  input  logic              lsb_store_done_in,
  output logic              commit_pc_en_out,
  output logic [ADDR_W-1:0] commit_pc_out,
  output logic              clear_branch_out
);

  localparam int unsigned CNT_W    = TAG_W + 1;
  localparam logic [1:0]  KIND_REG = 2'd0;
  localparam logic [1:0]  KIND_ST  = 2'd1;
  localparam logic [1:0]  KIND_BR  = 2'd3;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT_ST, ST_FLUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic [TAG_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_full, w_full_nxt;
  logic [ROB_DEPTH-1:0] r_valid, r_ready;

  logic [1:0]        r_ent_kind  [ROB_DEPTH];
  logic [REG_W-1:0]  r_ent_rd    [ROB_DEPTH];
  logic [DATA_W-1:0] r_ent_value [ROB_DEPTH];
  logic              r_ent_jen   [ROB_DEPTH];
  logic [ADDR_W-1:0] r_ent_ja    [ROB_DEPTH];

  logic              r_reg_en, r_store_en, r_pc_en, r_clear;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_value;
  logic [TAG_W-1:0]  r_tag;
  logic [ADDR_W-1:0] r_pc;

  logic              w_alloc, w_wb_hit, w_retire, w_flush;
  logic              w_head_ready, w_head_jump_en;
  logic [1:0]        w_head_kind;
  logic [DATA_W-1:0] w_head_value;
  logic [ADDR_W-1:0] w_head_jump_a;
  logic              w_reg_en_nxt, w_store_en_nxt, w_pc_en_nxt, w_clear_nxt;
  logic [REG_W-1:0]  w_rd_nxt;
  logic [DATA_W-1:0] w_value_nxt;
  logic [TAG_W-1:0]  w_tag_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;

  assign alloc_tag_out       = r_tail;
  assign full_out            = r_full;
  assign commit_reg_en_out   = r_reg_en;
  assign commit_rd_out       = r_rd;
  assign commit_value_out    = r_value;
  assign commit_tag_out      = r_tag;
  assign commit_store_en_out = r_store_en;
  assign commit_pc_en_out    = r_pc_en;
  assign commit_pc_out       = r_pc;
  assign clear_branch_out    = r_clear;

  assign w_alloc     = alloc_en_in && !r_full;
  assign w_wb_hit    = wb_en_in && r_valid[wb_tag_in];
  assign w_head_kind = r_ent_kind[r_head];

`ifdef COMMIT_WB_BYPASS_EN
  // A writeback aimed at the head is forwarded straight into the retire decision.
  logic w_wb_head;
  assign w_wb_head      = wb_en_in && (wb_tag_in == r_head);
  assign w_head_ready   = r_ready[r_head] || w_wb_head;
  assign w_head_value   = w_wb_head ? wb_value_in   : r_ent_value[r_head];
  assign w_head_jump_en = w_wb_head ? wb_jump_en_in : r_ent_jen[r_head];
  assign w_head_jump_a  = w_wb_head ? wb_jump_a_in  : r_ent_ja[r_head];
`else
  assign w_head_ready   = r_ready[r_head];
  assign w_head_value   = r_ent_value[r_head];
  assign w_head_jump_en = r_ent_jen[r_head];
  assign w_head_jump_a  = r_ent_ja[r_head];
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in)      r_state <= ST_RUN;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  // Retire decision and next commit outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_retire       = 1'b0;
    w_flush        = 1'b0;
    w_reg_en_nxt   = 1'b0;
    w_rd_nxt       = '0;
    w_value_nxt    = '0;
    w_tag_nxt      = '0;
    w_store_en_nxt = r_store_en;
    w_pc_en_nxt    = 1'b0;
    w_pc_nxt       = '0;
    w_clear_nxt    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_valid[r_head] && w_head_ready) begin
          if (w_head_kind == KIND_ST) begin
            w_store_en_nxt = 1'b1;
            w_state_nxt    = ST_WAIT_ST;
          end else begin
            if (w_head_kind != KIND_BR) begin
              w_reg_en_nxt = 1'b1;
              w_rd_nxt     = r_ent_rd[r_head];
              w_value_nxt  = w_head_value;
              w_tag_nxt    = r_head;
            end
            if ((w_head_kind != KIND_REG) && w_head_jump_en) begin
              w_pc_en_nxt = 1'b1;
              w_pc_nxt    = w_head_jump_a;
              w_clear_nxt = 1'b1;
              w_state_nxt = ST_FLUSH;
            end else begin
              w_retire = 1'b1;
            end
          end
        end
      end
      ST_WAIT_ST: begin
        if (lsb_store_done_in) begin
          w_store_en_nxt = 1'b0;
          w_retire       = 1'b1;
          w_state_nxt    = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Occupancy; full is registered from the next-state view so it depends on registers only
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) w_count_nxt = '0;
    else         w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_retire);
    w_full_nxt = (w_count_nxt == CNT_W'(ROB_DEPTH)) || (w_state_nxt == ST_FLUSH);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_valid    <= '0;
      r_ready    <= '0;
      r_reg_en   <= 1'b0;
      r_rd       <= '0;
      r_value    <= '0;
      r_tag      <= '0;
      r_store_en <= 1'b0;
      r_pc_en    <= 1'b0;
      r_pc       <= '0;
      r_clear    <= 1'b0;
    end else if (rdy_in) begin
      r_count    <= w_count_nxt;
      r_full     <= w_full_nxt;
      r_reg_en   <= w_reg_en_nxt;
      r_rd       <= w_rd_nxt;
      r_value    <= w_value_nxt;
      r_tag      <= w_tag_nxt;
      r_store_en <= w_store_en_nxt;
      r_pc_en    <= w_pc_en_nxt;
      r_pc       <= w_pc_nxt;
      r_clear    <= w_clear_nxt;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_valid <= '0;
        r_ready <= '0;
      end else begin
        if (w_retire) r_head <= r_head + TAG_W'(1);
        if (w_alloc)  r_tail <= r_tail + TAG_W'(1);
        if (w_wb_hit) r_ready[wb_tag_in] <= 1'b1;
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_ready[r_head] <= 1'b0;
        end
      end
    end else begin
      // Frozen: pulses drop, the store release level is held
      r_reg_en <= 1'b0;
      r_pc_en  <= 1'b0;
      r_pc     <= '0;
      r_clear  <= 1'b0;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !w_flush) begin
      if (w_wb_hit) begin
        r_ent_value[wb_tag_in] <= wb_value_in;
        r_ent_jen[wb_tag_in]   <= wb_jump_en_in;
        r_ent_ja[wb_tag_in]    <= wb_jump_a_in;
      end
      if (w_alloc) begin
        r_ent_kind[r_tail] <= alloc_kind_in;
        r_ent_rd[r_tail]   <= alloc_rd_in;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: directed scenarios plus randomized traffic checked against a queue-based ROB model.
`timescale 1ns/1ps
module tb_rob_commit_ctrl;

  localparam int DEPTH = 16;
`ifdef COMMIT_WB_BYPASS_EN
  localparam int WB_LAT = 1;
`else
  localparam int WB_LAT = 2;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_en_in;
  logic [1:0]  alloc_kind_in;
  logic [4:0]  alloc_rd_in;
  logic [3:0]  alloc_tag_out;
  logic        full_out;
  logic        wb_en_in;
  logic [3:0]  wb_tag_in;
  logic [31:0] wb_value_in;
  logic        wb_jump_en_in;
  logic [31:0] wb_jump_a_in;
  logic        commit_reg_en_out;
  logic [4:0]  commit_rd_out;
  logic [31:0] commit_value_out;
  logic [3:0]  commit_tag_out;
  logic        commit_store_en_out;
  logic        lsb_store_done_in;
  logic        commit_pc_en_out;
  logic [31:0] commit_pc_out;
  logic        clear_branch_out;

  rob_commit_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en_in(alloc_en_in), .alloc_kind_in(alloc_kind_in), .alloc_rd_in(alloc_rd_in),
    .alloc_tag_out(alloc_tag_out), .full_out(full_out),
    .wb_en_in(wb_en_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
    .wb_jump_en_in(wb_jump_en_in), .wb_jump_a_in(wb_jump_a_in),
    .commit_reg_en_out(commit_reg_en_out), .commit_rd_out(commit_rd_out),
    .commit_value_out(commit_value_out), .commit_tag_out(commit_tag_out),
    .commit_store_en_out(commit_store_en_out), .lsb_store_done_in(lsb_store_done_in),
    .commit_pc_en_out(commit_pc_en_out), .commit_pc_out(commit_pc_out),
    .clear_branch_out(clear_branch_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  kind;
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] value;
    bit          jen;
    logic [31:0] ja;
  } ent_t;

  // Reference model: program-order queue of in-flight instructions
  ent_t        m_q[$];
  int          m_tail;
  bit          m_store, m_flush;
  bit          exp_reg_en, exp_store, exp_pc_en, exp_clear, exp_full;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_pc;
  logic [3:0]  exp_tag;

  task automatic model_step();
    ent_t h, e;
    bit   full_now, pop, hr;
    if (rst_in) begin
      m_q.delete(); m_tail = 0; m_store = 0; m_flush = 0;
      exp_reg_en = 0; exp_rd = 0; exp_val = 0; exp_tag = 0; exp_store = 0;
      exp_pc_en = 0; exp_pc = 0; exp_clear = 0; exp_full = 0;
      return;
    end
    exp_reg_en = 0; exp_pc_en = 0; exp_pc = 0; exp_clear = 0;
    if (!rdy_in) return;
    full_now = (m_q.size() == DEPTH) || m_flush;
    if (m_flush) begin
      m_q.delete(); m_tail = 0; m_flush = 0;
    end else begin
      pop = 0;
      if (m_store) begin
        if (lsb_store_done_in) begin exp_store = 0; m_store = 0; pop = 1; end
      end else if (m_q.size() > 0) begin
        h  = m_q[0];
        hr = h.ready;
`ifdef COMMIT_WB_BYPASS_EN
        if (wb_en_in && wb_tag_in == h.tag) begin
          hr = 1; h.value = wb_value_in; h.jen = wb_jump_en_in; h.ja = wb_jump_a_in;
        end
`endif
        if (hr) begin
          if (h.kind == 2'd1) begin
            exp_store = 1; m_store = 1;
          end else begin
            if (h.kind != 2'd3) begin
              exp_reg_en = 1; exp_rd = h.rd; exp_val = h.value; exp_tag = h.tag;
            end
            if (h.kind != 2'd0 && h.jen) begin
              exp_pc_en = 1; exp_pc = h.ja; exp_clear = 1; m_flush = 1;
            end else pop = 1;
          end
        end
      end
      if (wb_en_in)
        for (int i = 0; i < m_q.size(); i++)
          if (m_q[i].tag == wb_tag_in) begin
            e = m_q[i]; e.ready = 1; e.value = wb_value_in; e.jen = wb_jump_en_in; e.ja = wb_jump_a_in;
            m_q[i] = e;
          end
      if (pop) m_q.delete(0);
      if (alloc_en_in && !full_now) begin
        e.tag = 4'(m_tail); e.kind = alloc_kind_in; e.rd = alloc_rd_in;
        e.ready = 0; e.value = 0; e.jen = 0; e.ja = 0;
        m_q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    exp_full = (m_q.size() == DEPTH) || m_flush;
  endtask

  // Advance one clock: model sees the same inputs as the DUT edge; outputs are sampled 1ns later
  task automatic tick();
    model_step();
    @(posedge clk_in); #1;
    alloc_en_in = 0; wb_en_in = 0; wb_jump_en_in = 0; lsb_store_done_in = 0;
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1;
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] rd);
    alloc_en_in = 1; alloc_kind_in = kind; alloc_rd_in = rd;
    tick();
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val, input bit jen, input logic [31:0] ja);
    wb_en_in = 1; wb_tag_in = tag; wb_value_in = val; wb_jump_en_in = jen; wb_jump_a_in = ja;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({commit_reg_en_out, commit_store_en_out, commit_pc_en_out, clear_branch_out, full_out} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000",
        {commit_reg_en_out, commit_store_en_out, commit_pc_en_out, clear_branch_out, full_out});
    end
    total++;
    if (alloc_tag_out !== 4'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", alloc_tag_out); end
    total++;
    if ({commit_pc_out, commit_value_out, commit_rd_out, commit_tag_out} !== 73'd0) begin
      bad++; $display("FAIL reset_data: got pc=%h val=%h want 0", commit_pc_out, commit_value_out);
    end
  endtask

  task automatic test_in_order();
    logic [3:0]  wtag [3] = '{4'd2, 4'd0, 4'd1};
    logic [31:0] wval [3] = '{32'hA, 32'hB, 32'hC};
    logic [31:0] xval [3] = '{32'hB, 32'hC, 32'hA};
    logic [3:0]  ctag[$];
    logic [4:0]  crd[$];
    logic [31:0] cval[$];
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'd0, 5'(i + 1));
    for (int i = 0; i < 9; i++) begin
      if (i < 3) wb(wtag[i], wval[i], 0, 0); else tick();
      if (commit_reg_en_out) begin
        ctag.push_back(commit_tag_out); crd.push_back(commit_rd_out); cval.push_back(commit_value_out);
      end
    end
    total++;
    if (ctag.size() != 3) begin bad++; $display("FAIL inorder_count: got %0d want 3", ctag.size()); end
    for (int i = 0; i < 3 && i < ctag.size(); i++) begin
      total++;
      if (ctag[i] !== 4'(i) || crd[i] !== 5'(i + 1) || cval[i] !== xval[i]) begin
        bad++; $display("FAIL inorder_%0d: got tag=%0d rd=%0d val=%h want tag=%0d rd=%0d val=%h",
          i, ctag[i], crd[i], cval[i], i, i + 1, xval[i]);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(2'd0, 5'd1);
      if (i == 14) begin
        total++;
        if (full_out !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", full_out); end
      end
    end
    total++;
    if (full_out !== 1'b1 || alloc_tag_out !== 4'd0) begin
      bad++; $display("FAIL full_16: got full=%b tag=%0d want full=1 tag=0", full_out, alloc_tag_out);
    end
    alloc(2'd0, 5'd2);
    total++;
    if (full_out !== 1'b1 || alloc_tag_out !== 4'd0) begin
      bad++; $display("FAIL full_17: got full=%b tag=%0d want full=1 tag=0", full_out, alloc_tag_out);
    end
  endtask

  task automatic test_store_ack();
    bit found;
    do_reset();
    alloc(2'd1, 5'd0);
    alloc(2'd0, 5'd7);
    wb(4'd1, 32'h77, 0, 0);
    wb(4'd0, 32'h0, 0, 0);
    for (int k = 0; k < 4 && !commit_store_en_out; k++) tick();
    total++;
    if (commit_store_en_out !== 1'b1) begin bad++; $display("FAIL store_release: got %b want 1", commit_store_en_out); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (commit_store_en_out !== 1'b1 || commit_reg_en_out !== 1'b0) begin
        bad++; $display("FAIL store_hold_%0d: got st=%b reg=%b want st=1 reg=0", k, commit_store_en_out, commit_reg_en_out);
      end
    end
    lsb_store_done_in = 1;
    tick();
    total++;
    if (commit_store_en_out !== 1'b0) begin bad++; $display("FAIL store_drop: got %b want 0", commit_store_en_out); end
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (commit_reg_en_out) begin found = 1; break; end
      tick();
    end
    total++;
    if (!found || commit_tag_out !== 4'd1 || commit_rd_out !== 5'd7 || commit_value_out !== 32'h77) begin
      bad++; $display("FAIL store_next: got seen=%b tag=%0d rd=%0d val=%h want seen=1 tag=1 rd=7 val=77",
        found, commit_tag_out, commit_rd_out, commit_value_out);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    alloc(2'd2, 5'd9);
    for (int i = 0; i < 3; i++) alloc(2'd0, 5'(10 + i));
    wb(4'd0, 32'h44, 1, 32'h1000);
    for (int k = 0; k < 4 && !commit_pc_en_out; k++) tick();
    total++;
    if (commit_pc_en_out !== 1'b1 || commit_pc_out !== 32'h1000 || clear_branch_out !== 1'b1) begin
      bad++; $display("FAIL br_redirect: got pc_en=%b pc=%h clr=%b want 1 00001000 1",
        commit_pc_en_out, commit_pc_out, clear_branch_out);
    end
    total++;
    if (commit_reg_en_out !== 1'b1 || commit_rd_out !== 5'd9 || commit_value_out !== 32'h44) begin
      bad++; $display("FAIL br_link: got reg=%b rd=%0d val=%h want 1 9 44", commit_reg_en_out, commit_rd_out, commit_value_out);
    end
    total++;
    if (full_out !== 1'b1) begin bad++; $display("FAIL br_full: got %b want 1", full_out); end
    tick();
    total++;
    if (full_out !== 1'b0 || alloc_tag_out !== 4'd0 || commit_pc_en_out !== 1'b0 || clear_branch_out !== 1'b0) begin
      bad++; $display("FAIL br_after: got full=%b tag=%0d pc_en=%b clr=%b want 0 0 0 0",
        full_out, alloc_tag_out, commit_pc_en_out, clear_branch_out);
    end
    alloc(2'd0, 5'd1);
    total++;
    if (alloc_tag_out !== 4'd1) begin bad++; $display("FAIL br_realloc: got %0d want 1", alloc_tag_out); end
  endtask

  task automatic test_rdy_freeze();
    bit found;
    do_reset();
    alloc(2'd1, 5'd0);
    alloc(2'd0, 5'd6);
    wb(4'd0, 32'h0, 0, 0);
    wb(4'd1, 32'h66, 0, 0);
    for (int k = 0; k < 4 && !commit_store_en_out; k++) tick();
    rdy_in = 0;
    for (int k = 0; k < 4; k++) begin
      lsb_store_done_in = 1;
      tick();
      total++;
      if (commit_store_en_out !== 1'b1 || commit_reg_en_out !== 1'b0 || commit_pc_en_out !== 1'b0 || alloc_tag_out !== 4'd2) begin
        bad++; $display("FAIL freeze_%0d: got st=%b reg=%b pc=%b tag=%0d want 1 0 0 2",
          k, commit_store_en_out, commit_reg_en_out, commit_pc_en_out, alloc_tag_out);
      end
    end
    rdy_in = 1;
    lsb_store_done_in = 1;
    tick();
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (commit_reg_en_out) begin found = 1; break; end
      tick();
    end
    total++;
    if (!found || commit_tag_out !== 4'd1 || commit_value_out !== 32'h66) begin
      bad++; $display("FAIL freeze_resume: got seen=%b tag=%0d val=%h want 1 1 66", found, commit_tag_out, commit_value_out);
    end
  endtask

  task automatic test_wb_latency();
    do_reset();
    alloc(2'd0, 5'd3);
    tick(); tick();
    wb(4'd0, 32'h33, 0, 0);
    total++;
    if (commit_reg_en_out !== (WB_LAT == 1)) begin
      bad++; $display("FAIL lat_t1: got %b want %b", commit_reg_en_out, (WB_LAT == 1));
    end
    tick();
    total++;
    if (commit_reg_en_out !== (WB_LAT == 2)) begin
      bad++; $display("FAIL lat_t2: got %b want %b", commit_reg_en_out, (WB_LAT == 2));
    end
  endtask

  task automatic test_random();
    logic [3:0] t;
    bit ok;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_in        = ($urandom_range(0, 199) == 0);
      rdy_in        = ($urandom_range(0, 7) != 0);
      alloc_en_in   = 1'($urandom_range(0, 1));
      alloc_kind_in = 2'($urandom_range(0, 3));
      alloc_rd_in   = 5'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0) t = m_q[$urandom_range(0, m_q.size() - 1)].tag;
        else t = 4'($urandom);
        ok = 1;
        foreach (m_q[i]) if (m_q[i].tag == t && m_q[i].ready) ok = 0;
        wb_en_in      = ok;
        wb_tag_in     = t;
        wb_value_in   = $urandom;
        wb_jump_en_in = ($urandom_range(0, 7) == 0);
        wb_jump_a_in  = $urandom;
      end
      lsb_store_done_in = m_store && ($urandom_range(0, 2) == 0);
      tick();
      total++;
      if (commit_reg_en_out !== exp_reg_en) begin
        bad++; $display("FAIL rnd_reg_en c=%0d: got %b want %b", c, commit_reg_en_out, exp_reg_en);
      end
      if (exp_reg_en) begin
        total++;
        if (commit_rd_out !== exp_rd || commit_value_out !== exp_val || commit_tag_out !== exp_tag) begin
          bad++; $display("FAIL rnd_reg_data c=%0d: got rd=%0d val=%h tag=%0d want rd=%0d val=%h tag=%0d",
            c, commit_rd_out, commit_value_out, commit_tag_out, exp_rd, exp_val, exp_tag);
        end
      end
      total++;
      if (commit_store_en_out !== exp_store || full_out !== exp_full || alloc_tag_out !== 4'(m_tail)) begin
        bad++; $display("FAIL rnd_ctl c=%0d: got st=%b full=%b tag=%0d want st=%b full=%b tag=%0d",
          c, commit_store_en_out, full_out, alloc_tag_out, exp_store, exp_full, m_tail);
      end
      total++;
      if (commit_pc_en_out !== exp_pc_en || commit_pc_out !== exp_pc || clear_branch_out !== exp_clear) begin
        bad++; $display("FAIL rnd_pc c=%0d: got pc_en=%b pc=%h clr=%b want pc_en=%b pc=%h clr=%b",
          c, commit_pc_en_out, commit_pc_out, clear_branch_out, exp_pc_en, exp_pc, exp_clear);
      end
    end
    rst_in = 0; rdy_in = 1;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    alloc_en_in = 0; alloc_kind_in = 0; alloc_rd_in = 0;
    wb_en_in = 0; wb_tag_in = 0; wb_value_in = 0; wb_jump_en_in = 0; wb_jump_a_in = 0;
    lsb_store_done_in = 0;
    #2;
    test_reset();
    test_in_order();
    test_full();
    test_store_ack();
    test_branch_flush();
    test_rdy_freeze();
    test_wb_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
